// File: rtl/div_pkg.sv
// Shared types and helpers for the divider issue/retire stage.
package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} div_state_t;

  // All-ones quotient returned for a divide-by-zero; callers cast to their width.
  function automatic logic [63:0] dbz_quotient(input int width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, registered occupancy count, combinational head read.
module div_op_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire stage feeding a combinational divider; captures results after a fixed settle time.
// Optional consistency check of non-zero-divisor results is enabled by defining DIV_CHECK_EN.
module div_issue_ctrl
  import div_pkg::div_state_t, div_pkg::DIVIDEND_W, div_pkg::DIVISOR_W, div_pkg::dbz_quotient;
#(
  parameter int DIVIDEND = DIVIDEND_W,
  parameter int DIVISOR  = DIVISOR_W,
  parameter int DEPTH    = 4,
  parameter int SETTLE   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] in_dividend,
  input  logic [DIVISOR-1:0]  in_divisor,
  output logic [DIVIDEND-1:0] div_dividend,
  output logic [DIVISOR-1:0]  div_divisor,
  input  logic [DIVIDEND-1:0] div_quotient,
  input  logic [DIVISOR-1:0]  div_remainder,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] out_quotient,
  output logic [DIVISOR-1:0]  out_remainder,
  output logic                out_dbz,
  output logic                out_err
);

  localparam int CNT_W  = $clog2(SETTLE + 1);
  localparam int PAIR_W = DIVIDEND + DIVISOR;

  div_state_t        state;
  div_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [PAIR_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              capture;
  logic              err_next;

  assign in_ready = !fifo_full;

  div_op_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .pop     (pop),
    .wr_data ({in_dividend, in_divisor}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef DIV_CHECK_EN
  localparam int CHK_W = DIVIDEND + DIVISOR;
  logic [CHK_W-1:0] recon;
  assign recon    = CHK_W'(div_quotient) * CHK_W'(div_divisor) + CHK_W'(div_remainder);
  assign err_next = (recon != CHK_W'(div_dividend)) || (div_remainder >= div_divisor);
`else
  assign err_next = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      div_pkg::IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = div_pkg::SETTLE;
        end
      end
      div_pkg::SETTLE: begin
        if (cnt == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = div_pkg::HOLD;
        end
      end
      div_pkg::HOLD: begin
        if (out_ready) state_next = div_pkg::IDLE;
      end
      default: state_next = div_pkg::IDLE;
    endcase
  end

  // Divider operands stay put outside SETTLE so the divider output is never disturbed mid-hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= div_pkg::IDLE;
      cnt           <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        {div_dividend, div_divisor} <= head;
        cnt                         <= CNT_W'(SETTLE);
      end else if (state == div_pkg::SETTLE) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        out_valid <= 1'b1;
        if (div_divisor == '0) begin
          out_quotient  <= DIVIDEND'(dbz_quotient(DIVIDEND));
          out_remainder <= div_dividend[DIVISOR-1:0];
          out_dbz       <= 1'b1;
          out_err       <= 1'b0;
        end else begin
          out_quotient  <= div_quotient;
          out_remainder <= div_remainder;
          out_dbz       <= 1'b0;
          out_err       <= err_next;
        end
      end else if (state == div_pkg::HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed cases plus randomized traffic against a queue model.
// Defining DIV_CHECK_EN also enables the corrupted-divider error case and an 8/4-bit exhaustive sweep.
module tb_div_issue_ctrl;

  localparam int DIVIDEND = 16;
  localparam int DIVISOR  = 8;
  localparam int DEPTH    = 4;
  localparam int SETTLE   = 1;
`ifdef DIV_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DIVIDEND-1:0] in_dividend;
  logic [DIVISOR-1:0]  in_divisor;
  logic [DIVIDEND-1:0] div_dividend;
  logic [DIVISOR-1:0]  div_divisor;
  logic [DIVIDEND-1:0] div_quotient;
  logic [DIVISOR-1:0]  div_remainder;
  logic                out_valid;
  logic                out_ready;
  logic [DIVIDEND-1:0] out_quotient;
  logic [DIVISOR-1:0]  out_remainder;
  logic                out_dbz;
  logic                out_err;
  logic                corrupt;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [DIVIDEND-1:0] q;
    logic [DIVISOR-1:0]  r;
    logic                dbz;
    logic                err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  div_issue_ctrl #(
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .DEPTH    (DEPTH),
    .SETTLE   (SETTLE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz),
    .out_err       (out_err)
  );

  // Ideal divider; drives garbage on divide-by-zero and can skew one remainder on request.
  always_comb begin
    div_quotient  = 16'hA5A5;
    div_remainder = 8'h3C;
    if (div_divisor != '0) begin
      div_quotient  = div_dividend / {8'd0, div_divisor};
      div_remainder = 8'(div_dividend % {8'd0, div_divisor});
      if (corrupt && div_dividend == 16'd100 && div_divisor == 8'd9)
        div_remainder = div_remainder + 8'd1;
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input logic bad);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = a[7:0]; e.dbz = 1'b1; e.err = 1'b0;
    end else begin
      e.q = a / {8'd0, b}; e.r = 8'(a % {8'd0, b}); e.dbz = 1'b0; e.err = 1'b0;
      if (bad && a == 16'd100 && b == 8'd9) begin
        e.r   = e.r + 8'd1;
        e.err = ERR_EN;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every offered result is compared to the oldest outstanding pair, also while stalled.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("quotient",  32'(out_quotient),  32'(exp_q[0].q));
          checkOutput("remainder", 32'(out_remainder), 32'(exp_q[0].r));
          checkOutput("dbz",       32'(out_dbz),       32'(exp_q[0].dbz));
          checkOutput("err",       32'(out_err),       32'(exp_q[0].err));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (!in_ready) checkOutput("ready_low_occupancy", 32'(exp_q.size() >= DEPTH), 32'd1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_dividend, in_divisor, corrupt));
        checkOutput("capacity", 32'(exp_q.size() <= DEPTH + 1), 32'd1);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b);
    int   tries = 0;
    logic took;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    do begin
      took = in_ready;
      tick();
      tries++;
    end while (!took && tries < 100);
    in_valid = 1'b0;
    if (!took) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

`ifdef DIV_CHECK_EN
  logic       s_in_valid, s_in_ready, s_out_valid, s_dbz, s_err;
  logic [7:0] s_in_dividend, s_div_dividend, s_div_quotient, s_out_quotient;
  logic [3:0] s_in_divisor, s_div_divisor, s_div_remainder, s_out_remainder;

  div_issue_ctrl #(
    .DIVIDEND (8),
    .DIVISOR  (4),
    .DEPTH    (2),
    .SETTLE   (2)
  ) small (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (s_in_valid),
    .in_ready      (s_in_ready),
    .in_dividend   (s_in_dividend),
    .in_divisor    (s_in_divisor),
    .div_dividend  (s_div_dividend),
    .div_divisor   (s_div_divisor),
    .div_quotient  (s_div_quotient),
    .div_remainder (s_div_remainder),
    .out_valid     (s_out_valid),
    .out_ready     (1'b1),
    .out_quotient  (s_out_quotient),
    .out_remainder (s_out_remainder),
    .out_dbz       (s_dbz),
    .out_err       (s_err)
  );

  always_comb begin
    s_div_quotient  = 8'h5A;
    s_div_remainder = 4'h9;
    if (s_div_divisor != '0) begin
      s_div_quotient  = s_div_dividend / {4'd0, s_div_divisor};
      s_div_remainder = 4'(s_div_dividend % {4'd0, s_div_divisor});
    end
  end

  task automatic runSweep();
    int n;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        s_in_valid    = 1'b1;
        s_in_dividend = 8'(a);
        s_in_divisor  = 4'(b);
        checkOutput("sweep_ready", 32'(s_in_ready), 32'd1);
        tick();
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
          tick();
          n++;
        end
        checkOutput("sweep_latency", 32'(n + 1), 32'd4);
        checkOutput("sweep_q", 32'(s_out_quotient), (b == 0) ? 32'hFF : 32'(a / b));
        checkOutput("sweep_r", 32'(s_out_remainder), (b == 0) ? 32'(a % 16) : 32'(a % b));
        checkOutput("sweep_dbz", 32'(s_dbz), 32'(b == 0));
        checkOutput("sweep_err", 32'(s_err), 32'd0);
        tick();
      end
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int accepted;
    logic [15:0] a;
    logic [7:0]  b;

    rst         = 1'b0;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b1;
    corrupt     = 1'b0;
`ifdef DIV_CHECK_EN
    s_in_valid    = 1'b0;
    s_in_dividend = '0;
    s_in_divisor  = '0;
`endif
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_div_dividend", 32'(div_dividend), 32'd0);
    checkOutput("reset_div_divisor", 32'(div_divisor), 32'd0);
    checkOutput("reset_out_quotient", 32'(out_quotient), 32'd0);
    checkOutput("reset_out_remainder", 32'(out_remainder), 32'd0);
    checkOutput("reset_out_dbz", 32'(out_dbz), 32'd0);
    checkOutput("reset_out_err", 32'(out_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checkOutput("post_reset_ready", 32'(in_ready), 32'd1);

    // Latency counted from the cycle the pair is first offered; the scoreboard checks 142 r 6.
    in_valid    = 1'b1;
    in_dividend = 16'd1000;
    in_divisor  = 8'd7;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) in_valid = 1'b0;
    end while (!out_valid && lat < 20);
    checkOutput("latency", 32'(lat), 32'(SETTLE + 2));
    waitDrain();

    applyStimulus(16'd65535, 8'd255);
    applyStimulus(16'd255, 8'd255);
    applyStimulus(16'd0, 8'd9);
    applyStimulus(16'd5, 8'd0);
    applyStimulus(16'd20, 8'd3);
    waitDrain();

    corrupt = 1'b1;
    applyStimulus(16'd100, 8'd9);
    waitDrain();
    corrupt = 1'b0;

    // Backpressure: five pairs fit (four queued plus one held), the sixth is refused.
    out_ready = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid    = 1'b1;
      in_dividend = 16'(i * 1000 + 7);
      in_divisor  = 8'(i + 3);
      checkOutput("bp_in_ready", 32'(in_ready), 32'(i < 5));
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("bp_accepted", 32'(accepted), 32'd5);
    repeat (5) tick();
    checkOutput("bp_stalled_valid", 32'(out_valid), 32'd1);
    waitDrain();

    // Reset while a pair settles with three more queued.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(16'(300 + i), 8'(i + 2));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset_div_dividend", 32'(div_dividend), 32'd0);
    repeat (2) tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
    end
    applyStimulus(16'd77, 8'd5);
    waitDrain();

    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'hFFFF;
        1:       a = 16'($urandom_range(0, 20));
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = 8'd0;
        1:       b = 8'hFF;
        2:       b = 8'd1;
        default: b = 8'($urandom);
      endcase
      in_valid    = ($urandom_range(0, 3) != 0);
      in_dividend = a;
      in_divisor  = b;
      out_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    waitDrain();

`ifdef DIV_CHECK_EN
    runSweep();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
